// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz defaults, 800x525 total).
// Produces registered pixel/line counters, active-low syncs, a visible-area
// flag, a frame-start pulse and a pixel-advance strobe.
// Optional feature: define VGA_CLKDIV_EN to run from a 50 MHz clock with an
// internal divide-by-two pixel tick; undefined, every 25 MHz edge is a tick.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       pix_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // After reset the raster is parked; the first tick places it at (0,0)
  // rather than advancing, so the first visible pixel gets a full period.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic       w_tick;
  logic [9:0] w_xNext;
  logic [9:0] w_yNext;
  logic       w_hsyncNext;
  logic       w_vsyncNext;
  logic       w_videoOnNext;
  logic       w_frameStartNext;

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_videoOn;
  logic       r_frameStart;
  logic       r_pixTick;

`ifdef VGA_CLKDIV_EN
  logic r_toggle;

  // Divide-by-two phase: the tick lands on edges where the toggle reads 1,
  // so the first tick after reset release is the second clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= 1'b0;
    end else begin
      r_toggle <= ~r_toggle;
    end
  end

  assign w_tick = r_toggle;
`else
  assign w_tick = 1'b1;
`endif

  // Raster state register: parked after reset, running after first tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next raster position: start at origin, then step x and wrap into y.
  always_comb begin
    w_stateNext = r_state;
    w_xNext     = r_x;
    w_yNext     = r_y;
    if (w_tick) begin
      if (r_state == ST_IDLE) begin
        w_stateNext = ST_RUN;
        w_xNext     = 10'd0;
        w_yNext     = 10'd0;
      end else if (r_x == H_LAST) begin
        w_xNext = 10'd0;
        if (r_y == V_LAST) begin
          w_yNext = 10'd0;
        end else begin
          w_yNext = r_y + 10'd1;
        end
      end else begin
        w_xNext = r_x + 10'd1;
      end
    end
  end

  // Decode the flags from the position that will be registered alongside
  // them, so flags and counters always describe the same pixel.
  always_comb begin
    w_hsyncNext      = ~((w_xNext >= HS_START) && (w_xNext < HS_END));
    w_vsyncNext      = ~((w_yNext >= VS_START) && (w_yNext < VS_END));
    w_videoOnNext    = (w_xNext < H_VIS_END) && (w_yNext < V_VIS_END);
    w_frameStartNext = (w_xNext == 10'd0) && (w_yNext == 10'd0);
  end

  // Output registers: update only on pixel ticks, hold in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_videoOn    <= 1'b0;
      r_frameStart <= 1'b0;
      r_pixTick    <= 1'b0;
    end else begin
      r_pixTick <= w_tick;
      if (w_tick) begin
        r_x          <= w_xNext;
        r_y          <= w_yNext;
        r_hsync      <= w_hsyncNext;
        r_vsync      <= w_vsyncNext;
        r_videoOn    <= w_videoOnNext;
        r_frameStart <= w_frameStartNext;
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_videoOn;
  assign frame_start = r_frameStart;
  assign pix_tick    = r_pixTick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one default-sized instance and one small
// instance (27x17 raster) so full-frame wrap can be exercised quickly.
// Honours VGA_CLKDIV_EN the same way as the design.
module tb_vga_timing_gen;

`ifdef VGA_CLKDIV_EN
  localparam int TPC = 2;
`else
  localparam int TPC = 1;
`endif

  int HV [2] = '{640, 20};
  int HF [2] = '{16, 2};
  int HS [2] = '{96, 3};
  int HB [2] = '{48, 2};
  int VV [2] = '{480, 10};
  int VF [2] = '{10, 2};
  int VS [2] = '{2, 2};
  int VB [2] = '{33, 3};

  logic       clk;
  logic       rst;
  logic [9:0] dx  [2];
  logic [9:0] dy  [2];
  logic       dhs [2];
  logic       dvs [2];
  logic       dvo [2];
  logic       dfs [2];
  logic       dpt [2];

  int nChecks = 0;
  int nFails  = 0;

  // Model state: linear position in the frame (-1 = parked after reset).
  int   mPos  [2];
  logic mTick [2];
  int   mPhase;
  logic mValid = 1'b0;
  logic tickNow;

  vga_timing_gen dutFull (
    .clk(clk), .rst(rst), .x(dx[0]), .y(dy[0]), .hsync(dhs[0]),
    .vsync(dvs[0]), .video_on(dvo[0]), .frame_start(dfs[0]), .pix_tick(dpt[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dutSmall (
    .clk(clk), .rst(rst), .x(dx[1]), .y(dy[1]), .hsync(dhs[1]),
    .vsync(dvs[1]), .video_on(dvo[1]), .frame_start(dfs[1]), .pix_tick(dpt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int hTotal(input int i);
    return HV[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int frameTicks(input int i);
    return hTotal(i) * (VV[i] + VF[i] + VS[i] + VB[i]);
  endfunction

`ifdef VGA_CLKDIV_EN
  assign tickNow = (mPhase % 2) == 1;
`else
  assign tickNow = 1'b1;
`endif

  // Reference model: count ticks, derive position arithmetically.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mPos[i]  <= -1;
        mTick[i] <= 1'b0;
      end else if (tickNow) begin
        mPos[i]  <= (mPos[i] < 0) ? 0 : ((mPos[i] + 1) % frameTicks(i));
        mTick[i] <= 1'b1;
      end else begin
        mTick[i] <= 1'b0;
      end
    end
    if (rst) begin
      mValid <= 1'b1;
      mPhase <= 0;
    end else begin
      mPhase <= mPhase + 1;
    end
  end

  int lineArm = 0, lineDone = 0, hsLow = 0, firstHs = -1, firstOff = -1;
  int fArm = 0, fLen = 0, vsLow = 0, framesDone = 0;

  // Per-cycle comparison against the model plus line/frame statistics.
  always @(negedge clk) begin
    if (mValid) begin
      for (int i = 0; i < 2; i++) begin
        int ex, ey, eh, ev, eo, ef;
        if (mPos[i] < 0) begin
          ex = 0; ey = 0; eh = 1; ev = 1; eo = 0; ef = 0;
        end else begin
          ex = mPos[i] % hTotal(i);
          ey = mPos[i] / hTotal(i);
          eh = (ex >= HV[i] + HF[i] && ex < HV[i] + HF[i] + HS[i]) ? 0 : 1;
          ev = (ey >= VV[i] + VF[i] && ey < VV[i] + VF[i] + VS[i]) ? 0 : 1;
          eo = (ex < HV[i] && ey < VV[i]) ? 1 : 0;
          ef = (mPos[i] == 0) ? 1 : 0;
        end
        checkOutput($sformatf("x[%0d]", i), dx[i], ex);
        checkOutput($sformatf("y[%0d]", i), dy[i], ey);
        checkOutput($sformatf("hsync[%0d]", i), dhs[i], eh);
        checkOutput($sformatf("vsync[%0d]", i), dvs[i], ev);
        checkOutput($sformatf("video_on[%0d]", i), dvo[i], eo);
        checkOutput($sformatf("frame_start[%0d]", i), dfs[i], ef);
        checkOutput($sformatf("pix_tick[%0d]", i), dpt[i], mTick[i]);
      end

      if (mPos[0] < 0) begin
        lineArm = 1; hsLow = 0; firstHs = -1; firstOff = -1;
      end else if (dpt[0] && lineArm == 1 && dy[0] == 10'd0) begin
        if (!dhs[0]) begin
          hsLow++;
          if (firstHs < 0) firstHs = dx[0];
        end
        if (!dvo[0] && firstOff < 0) firstOff = dx[0];
        if (dx[0] == 10'd799) begin
          checkOutput("line_hsync_ticks", hsLow, 96);
          checkOutput("line_hsync_first_x", firstHs, 656);
          checkOutput("line_video_off_x", firstOff, 640);
          lineArm  = 0;
          lineDone = 1;
        end
      end

      if (mPos[1] < 0) begin
        fArm = 0;
      end else if (dpt[1]) begin
        if (dfs[1]) begin
          if (fArm == 1) begin
            checkOutput("small_frame_ticks", fLen, 459);
            checkOutput("small_vsync_ticks", vsLow, 54);
            framesDone++;
          end
          fArm  = 1;
          fLen  = 1;
          vsLow = dvs[1] ? 0 : 1;
        end else begin
          fLen++;
          if (!dvs[1]) vsLow++;
        end
      end
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(3);
    rst = 1'b0;
`ifdef VGA_CLKDIV_EN
    applyStimulus(1);
    checkOutput("pin_e1_frame_start", dfs[0], 0);
    checkOutput("pin_e1_pix_tick", dpt[0], 0);
    checkOutput("pin_e1_video_on", dvo[0], 0);
    applyStimulus(1);
    checkOutput("pin_e2_x", dx[0], 0);
    checkOutput("pin_e2_frame_start", dfs[0], 1);
    checkOutput("pin_e2_video_on", dvo[0], 1);
    checkOutput("pin_e2_pix_tick", dpt[0], 1);
    applyStimulus(1);
    checkOutput("pin_e3_pix_tick", dpt[0], 0);
    checkOutput("pin_e3_frame_start_hold", dfs[0], 1);
    applyStimulus(1);
    checkOutput("pin_e4_x", dx[0], 1);
    checkOutput("pin_e4_frame_start", dfs[0], 0);
`else
    applyStimulus(1);
    checkOutput("pin_e1_x", dx[0], 0);
    checkOutput("pin_e1_y", dy[0], 0);
    checkOutput("pin_e1_frame_start", dfs[0], 1);
    checkOutput("pin_e1_video_on", dvo[0], 1);
    applyStimulus(1);
    checkOutput("pin_e2_x", dx[0], 1);
    checkOutput("pin_e2_frame_start", dfs[0], 0);
`endif
    applyStimulus(2600 * TPC);

    rst = 1'b1;
    applyStimulus(1);
    checkOutput("pin_rst_x", dx[0], 0);
    checkOutput("pin_rst_y", dy[0], 0);
    checkOutput("pin_rst_hsync", dhs[0], 1);
    checkOutput("pin_rst_vsync", dvs[0], 1);
    checkOutput("pin_rst_video_on", dvo[0], 0);
    checkOutput("pin_rst_pix_tick", dpt[0], 0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      applyStimulus($urandom_range(50, 1500));
      rst = 1'b1;
      applyStimulus($urandom_range(1, 3));
      rst = 1'b0;
    end
    applyStimulus(1200 * TPC);

    checkOutput("line_stats_seen", (lineDone != 0) ? 1 : 0, 1);
    checkOutput("frame_stats_seen", (framesDone > 0) ? 1 : 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, single clock for all logic.
REQ-010 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-011 SHALL have port x, output, 10, current horizontal pixel count.
REQ-012 SHALL have port y, output, 10, current line count.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-015 SHALL have port video_on, output, 1, high only inside the visible area.
REQ-016 SHALL have port frame_start, output, 1, one-pixel pulse at pixel (0,0).
REQ-017 SHALL have port pix_tick, output, 1, pixel-advance strobe, for DAC clock or enable.

Function
REQ-018 SHALL hold H_TOTAL = sum of the H_* parameters (800) and V_TOTAL = sum of the V_* parameters (525).
REQ-019 SHALL advance only on clk edges where the pixel tick is active; all outputs SHALL hold between ticks.
REQ-020 SHALL increment x by 1 per tick; at x = H_TOTAL-1 the next tick SHALL set x to 0 and increment y.
REQ-021 SHALL wrap y from V_TOTAL-1 to 0 on the same tick that x wraps, so the successor of (799,524) is (0,0).
REQ-022 SHALL keep x and y counting through blanking; the downstream colour logic gates with video_on.
REQ-023 SHALL drive hsync = 0 exactly when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
REQ-024 SHALL drive vsync = 0 exactly when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
REQ-025 SHALL drive video_on = 1 exactly when x < H_VISIBLE and y < V_VISIBLE.
REQ-026 SHALL drive frame_start = 1 exactly when x = 0 and y = 0, and for one pixel period only.
REQ-027 SHALL drive all outputs from registers; hsync, vsync, video_on and frame_start SHALL always be consistent with the x and y presented in the same cycle.
REQ-028 SHALL keep x, y, hsync and vsync free of glitches between registered updates.

Reset
REQ-029 On rst = 1 at a clk edge, SHALL set x = 0, y = 0, hsync = 1, vsync = 1, video_on = 0, frame_start = 0, pix_tick = 0 and clear the tick divider.
REQ-030 On the first pixel tick after rst deasserts, SHALL present x = 0, y = 0, video_on = 1, frame_start = 1.
REQ-031 Reset asserted mid-frame or mid-line SHALL take effect at the next clk edge, regardless of tick phase.

Configuration
REQ-032 With macro VGA_CLKDIV_EN defined, SHALL assume clk = 50 MHz and generate an internal toggle that resets to 0; the pixel tick SHALL be active on edges where the toggle is 1, so the first tick is the second clk edge after reset release and pix_tick is high every other cycle.
REQ-033 With VGA_CLKDIV_EN undefined, SHALL assume clk = 25 MHz; every clk edge SHALL be a pixel tick, pix_tick SHALL be constantly 1 after reset, and the divider logic SHALL be absent.

Verification
REQ-034 Reset release, macro undefined -> first edge gives x=0, y=0, frame_start=1, video_on=1; next edge gives x=1, frame_start=0.
REQ-035 Run one full line -> hsync low for exactly 96 ticks starting at x=656; video_on falls at x=640; x wraps 799->0 with y+1.
REQ-036 Run one full frame -> vsync low on lines 490-491 only; (799,524) is followed by (0,0) with frame_start=1; frame length is 420000 ticks.
REQ-037 Macro defined -> outputs change only every 2nd clk; pix_tick alternates 0/1; first x=0, frame_start=1 appears on the 2nd edge after release; frame length is 840000 clks.
REQ-038 Assert rst at x=700, y=300 for one cycle -> next edge gives x=0, y=0, hsync=1, vsync=1, video_on=0; counting restarts per REQ-030.
